// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hold/flush/bubble/freeze controller for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int REG_BITS     = 5,
    parameter int CNT_W        = 16,
    parameter int MISS_TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] D_rs1,
    input  logic [REG_BITS-1:0] D_rs2,
    input  logic                D_use_rs1,
    input  logic                D_use_rs2,
    input  logic                EX_valid,
    input  logic                EX_is_load,
    input  logic [REG_BITS-1:0] EX_rd,
    input  logic                EX_mispredict,
    input  logic                MEM_miss,
    input  logic                MEM_ready,
    output logic                stall_F,
    output logic                stall_D,
    output logic                flush_D,
    output logic                bubble_EX,
    output logic                MEM_stall,
    output logic                miss_timeout,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } state_t;

    localparam int TW = $clog2(MISS_TIMEOUT + 1);

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   miss_timer;
    logic            load_use;
    logic            evaluate;

    always_comb begin
        load_use = EX_valid && EX_is_load && (EX_rd != '0) &&
                   ((D_use_rs1 && (D_rs1 == EX_rd)) || (D_use_rs2 && (D_rs2 == EX_rd)));
    end

    // evaluate marks cycles where the pipeline moves: RUN without a miss, or the MISS release cycle
    always_comb begin
        state_next = state;
        MEM_stall  = 1'b0;
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        flush_D    = 1'b0;
        bubble_EX  = 1'b0;
        evaluate   = 1'b0;
        case (state)
            RUN: begin
                if (MEM_miss) begin
                    MEM_stall  = 1'b1;
                    state_next = MISS;
                end else begin
                    evaluate = 1'b1;
                end
            end
            MISS: begin
                if (MEM_ready) begin
                    state_next = RUN;
                    evaluate   = 1'b1;
                end else begin
                    MEM_stall = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
        if (evaluate) begin
            if (EX_mispredict) begin
                flush_D   = 1'b1;
                bubble_EX = 1'b1;
            end else if (load_use) begin
                stall_F   = 1'b1;
                stall_D   = 1'b1;
                bubble_EX = 1'b1;
            end
        end
        if (rst) begin
            state_next = RUN;
            MEM_stall  = 1'b0;
            stall_F    = 1'b0;
            stall_D    = 1'b0;
            flush_D    = 1'b0;
            bubble_EX  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            miss_timer   <= '0;
            miss_timeout <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            state <= state_next;
            // timer holds the number of MISS cycles completed; it saturates so the flag stays meaningful
            if (state == MISS) begin
                if (miss_timer != TW'(MISS_TIMEOUT))
                    miss_timer <= miss_timer + 1'b1;
                if (miss_timer == TW'(MISS_TIMEOUT - 1))
                    miss_timeout <= 1'b1;
            end else begin
                miss_timer <= '0;
            end
            if ((stall_D || MEM_stall) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_D && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int RB   = 5;
    localparam int CW   = 4;
    localparam int TO   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [RB-1:0] D_rs1, D_rs2, EX_rd;
    logic D_use_rs1, D_use_rs2, EX_valid, EX_is_load, EX_mispredict, MEM_miss, MEM_ready;
    logic stall_F, stall_D, flush_D, bubble_EX, MEM_stall, miss_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_BITS(RB), .CNT_W(CW), .MISS_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .D_rs1(D_rs1), .D_rs2(D_rs2), .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2),
        .EX_valid(EX_valid), .EX_is_load(EX_is_load), .EX_rd(EX_rd),
        .EX_mispredict(EX_mispredict), .MEM_miss(MEM_miss), .MEM_ready(MEM_ready),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .bubble_EX(bubble_EX),
        .MEM_stall(MEM_stall), .miss_timeout(miss_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        bit sf, sd, fd, be, ms, to;
        int sc, fc;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // reference model: pipeline state described by the rules, not by signal encoding
    bit m_waiting;
    int m_miss_cycles;
    bit m_to;
    int m_stalls, m_flushes;

    task automatic set_idle();
        rst = 0; D_rs1 = 0; D_rs2 = 0; D_use_rs1 = 0; D_use_rs2 = 0;
        EX_valid = 0; EX_is_load = 0; EX_rd = 0; EX_mispredict = 0;
        MEM_miss = 0; MEM_ready = 0;
    endtask

    task automatic issue();
        exp_t e;
        bit frozen, moving, hazard;
        hazard = EX_valid && EX_is_load && (EX_rd != 0) &&
                 ((D_use_rs1 && D_rs1 == EX_rd) || (D_use_rs2 && D_rs2 == EX_rd));
        if (m_waiting) frozen = !MEM_ready;
        else           frozen = MEM_miss;
        frozen = frozen && !rst;
        moving = !rst && !frozen;
        e.ms  = frozen;
        e.fd  = moving && EX_mispredict;
        e.sd  = moving && !EX_mispredict && hazard;
        e.sf  = e.sd;
        e.be  = e.fd || e.sd;
        e.to  = m_to;
        e.sc  = m_stalls;
        e.fc  = m_flushes;
        e.cyc = cyc;
        sb.push_back(e);
        if (rst) begin
            m_waiting = 0; m_miss_cycles = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (m_waiting) begin
                m_miss_cycles++;
                if (m_miss_cycles >= TO) m_to = 1;
                if (MEM_ready) begin
                    m_waiting = 0;
                    m_miss_cycles = 0;
                end
            end else begin
                m_waiting = MEM_miss;
            end
            if (e.sd || e.ms) m_stalls  = (m_stalls  < CMAX) ? m_stalls + 1  : CMAX;
            if (e.fd)         m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input int act, input int req, input int c);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("stall_F",      int'(stall_F),      int'(e.sf), e.cyc);
            check("stall_D",      int'(stall_D),      int'(e.sd), e.cyc);
            check("flush_D",      int'(flush_D),      int'(e.fd), e.cyc);
            check("bubble_EX",    int'(bubble_EX),    int'(e.be), e.cyc);
            check("MEM_stall",    int'(MEM_stall),    int'(e.ms), e.cyc);
            check("miss_timeout", int'(miss_timeout), int'(e.to), e.cyc);
            check("stall_cnt",    int'(stall_cnt),    e.sc,       e.cyc);
            check("flush_cnt",    int'(flush_cnt),    e.fc,       e.cyc);
        end
    end

    task automatic load_use_cycle(input logic [RB-1:0] rd);
        EX_valid = 1; EX_is_load = 1; EX_rd = rd; D_rs1 = rd; D_use_rs1 = 1;
        issue();
        set_idle();
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        issue();
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1;
        @(posedge clk);
        #1;
        m_waiting = 0; m_miss_cycles = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
        do_reset();
        issue();
        issue();

        // load-use, then the EX_rd=0 case
        load_use_cycle(5'd5);
        issue();
        load_use_cycle(5'd0);
        issue();

        // mispredict together with a load-use match
        EX_valid = 1; EX_is_load = 1; EX_rd = 5'd7; D_rs2 = 5'd7; D_use_rs2 = 1; EX_mispredict = 1;
        issue();
        set_idle();
        issue();

        // miss wait with release four cycles later, mispredict held throughout
        MEM_miss = 1; EX_mispredict = 1;
        repeat (4) issue();
        MEM_ready = 1;
        issue();
        set_idle();
        issue();

        // timeout: ready withheld for 20 cycles, then released, then reset
        MEM_miss = 1;
        repeat (21) issue();
        MEM_ready = 1;
        issue();
        set_idle();
        repeat (2) issue();
        do_reset();
        issue();

        // reset mid-miss
        MEM_miss = 1;
        repeat (3) issue();
        do_reset();
        repeat (2) issue();

        // flush counter saturation
        EX_mispredict = 1;
        repeat (20) issue();
        set_idle();
        issue();
        do_reset();

        // randomized traffic with small register space so hazards are frequent
        for (int i = 0; i < 800; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            D_rs1         = RB'($urandom_range(0, 3));
            D_rs2         = RB'($urandom_range(0, 3));
            EX_rd         = RB'($urandom_range(0, 3));
            D_use_rs1     = $urandom_range(0, 1);
            D_use_rs2     = $urandom_range(0, 1);
            EX_valid      = ($urandom_range(0, 3) != 0);
            EX_is_load    = $urandom_range(0, 1);
            EX_mispredict = ($urandom_range(0, 5) == 0);
            MEM_miss      = ($urandom_range(0, 7) == 0);
            MEM_ready     = ($urandom_range(0, 5) == 0);
            issue();
        end
        set_idle();
        issue();

        @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
